ls_datapath_fsm: RTL and testbench

// Parametrised multi-cycle load/store datapath: register file, effective-address adder and word-addressed data memory.

---
 rtl/ls_pkg.sv | 17 +
 rtl/ls_regfile.sv | 44 ++++
 rtl/ls_datapath_fsm.sv | 173 +++++++++++++++++
 tb/tb_ls_datapath_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared definitions for the multi-cycle load/store datapath.
// Contents:
//   OP_LW / OP_SW : encoding of the single-bit op input
//   state_t       : sequencer states, IDLE=0, ADDR=1, MEM=2, WB=3
package ls_pkg;

  localparam logic OP_LW = 1'b0;
  localparam logic OP_SW = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/ls_regfile.sv
// Register file for the load/store datapath: 2**RAW entries of DW bits.
// R0 is hard-wired to zero; writes to it are dropped.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset (clears all entries)
//   we, waddr, wdata : single write port
//   raddr_a/rdata_a  : combinational read port used by the sequencer (rs / rt)
//   raddr_b/rdata_b  : combinational debug read port
module ls_regfile
  import ls_pkg::*;
#(
  parameter int DW  = 16,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [RAW-1:0] raddr_a,
  output logic [DW-1:0]  rdata_a,
  input  logic [RAW-1:0] raddr_b,
  output logic [DW-1:0]  rdata_b
);

  localparam int NREG = 2 ** RAW;

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, but the explicit zero keeps R0 independent of
  // the array contents.
  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/ls_datapath_fsm.sv
// Multi-cycle load/store datapath: register file, effective-address adder and
// word-addressed data memory, sequenced IDLE -> ADDR -> MEM -> WB -> IDLE.
//   LW: R[rt] <= MEM[R[rs] + sext(offset)]
//   SW: MEM[R[rs] + sext(offset)] <= R[rt]
// Effective addresses at or above DEPTH abort the access and flag err.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, op, rs, rt, offset: request, sampled only in IDLE
//   busy                     : high in ADDR, MEM and WB
//   done, err                : one-cycle completion pulse in WB, err valid with it
//   mem_out                  : last data returned by a successful LW
//   rf_we, rf_waddr, rf_wdata: register preload, honoured only in IDLE
//   rf_raddr, rf_rdata       : combinational debug read of the register file
module ls_datapath_fsm
  import ls_pkg::*;
#(
  parameter int DW    = 16,
  parameter int RAW   = 5,
  parameter int OFFW  = 8,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [RAW-1:0]  rs,
  input  logic [RAW-1:0]  rt,
  input  logic [OFFW-1:0] offset,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [DW-1:0]   mem_out,
  input  logic            rf_we,
  input  logic [RAW-1:0]  rf_waddr,
  input  logic [DW-1:0]   rf_wdata,
  input  logic [RAW-1:0]  rf_raddr,
  output logic [DW-1:0]   rf_rdata
);

  localparam int MAW = $clog2(DEPTH);
  // DEPTH widened by one bit so an EA of all ones still compares correctly.
  localparam logic [DW:0] DEPTH_X = (DW + 1)'(DEPTH);

  function automatic logic signed [DW-1:0] sext_off(input logic signed [OFFW-1:0] o);
    return DW'(o);
  endfunction

  state_t                 state;
  logic                   op_q;
  logic [RAW-1:0]         rs_q;
  logic [RAW-1:0]         rt_q;
  logic signed [OFFW-1:0] off_q;
  logic [MAW-1:0]         ea_q;
  logic                   err_q;

  logic [DW-1:0]          mem [DEPTH];

  logic [RAW-1:0]         rfa_raddr;
  logic [DW-1:0]          rfa_rdata;
  logic                   rf_we_int;
  logic [RAW-1:0]         rf_waddr_int;
  logic [DW-1:0]          rf_wdata_int;

  logic signed [DW-1:0]   off_ext;
  logic [DW-1:0]          ea_sum;
  logic                   ea_over;
  logic                   lw_ok;

  // The sequencer port reads the base in ADDR and the store data in MEM, so
  // both see any preload or writeback that landed before that cycle.
  assign rfa_raddr = (state == S_ADDR) ? rs_q : rt_q;

  assign off_ext = sext_off(off_q);
  assign ea_sum  = rfa_rdata + $unsigned(off_ext);
  assign ea_over = ({1'b0, ea_sum} >= DEPTH_X);
  assign lw_ok   = (op_q == OP_LW) && !err_q;

  // Preload and writeback share the one write port; they live in disjoint
  // states so no arbitration is needed.
  always_comb begin
    rf_we_int    = 1'b0;
    rf_waddr_int = rf_waddr;
    rf_wdata_int = rf_wdata;
    if (state == S_IDLE) begin
      rf_we_int = rf_we;
    end else if (state == S_WB) begin
      rf_we_int    = lw_ok;
      rf_waddr_int = rt_q;
      rf_wdata_int = mem_out;
    end
  end

  ls_regfile #(
    .DW  (DW),
    .RAW (RAW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we_int),
    .waddr   (rf_waddr_int),
    .wdata   (rf_wdata_int),
    .raddr_a (rfa_raddr),
    .rdata_a (rfa_rdata),
    .raddr_b (rf_raddr),
    .rdata_b (rf_rdata)
  );

  // Request latch, EA register and memory write: data only, no reset.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) begin
      op_q  <= op;
      rs_q  <= rs;
      rt_q  <= rt;
      off_q <= offset;
    end
    if (state == S_ADDR) begin
      ea_q <= ea_sum[MAW-1:0];
    end
    if ((state == S_MEM) && (op_q == OP_SW) && !err_q) begin
      mem[ea_q] <= rfa_rdata;
    end
  end

  // Sequencer with registered handshake outputs. mem_out doubles as the
  // synchronous read register, so it already holds the LW data during WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_q   <= 1'b0;
      mem_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ADDR;
            busy  <= 1'b1;
          end
        end
        // ADDR -> MEM boundary: EA range check registered
        S_ADDR: begin
          err_q <= ea_over;
          state <= S_MEM;
        end
        // MEM -> WB boundary: LW read data captured, completion raised
        S_MEM: begin
          if (lw_ok) begin
            mem_out <= mem[ea_q];
          end
          done  <= 1'b1;
          err   <= err_q;
          state <= S_WB;
        end
        // WB -> IDLE boundary: writeback commits through the regfile port
        S_WB: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ls_datapath_fsm.sv
// Directed bench for ls_datapath_fsm with default parameters.
module tb_ls_datapath_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [7:0]  offset = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] mem_out;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [15:0] rf_wdata = '0;
  logic [4:0]  rf_raddr = '0;
  logic [15:0] rf_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ls_datapath_fsm #(
    .DW    (16),
    .RAW   (5),
    .OFFW  (8),
    .DEPTH (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .offset   (offset),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_out  (mem_out),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] idx, input logic [15:0] exp);
    rf_raddr = idx;
    #1;
    chk(tag, rf_rdata, exp);
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    rf_we    = 1'b1;
    rf_waddr = a;
    rf_wdata = d;
    @(posedge clk); #1;
    rf_we = 1'b0;
  endtask

  // Issues one request and checks the handshake edge by edge. With junk set,
  // start and rf_we stay asserted (with different operands) while busy.
  task automatic run_op(input string tag, input logic o, input logic [4:0] s,
                        input logic [4:0] t, input logic [7:0] off,
                        input logic exp_err, input logic [15:0] exp_mo,
                        input logic junk);
    start = 1'b1; op = o; rs = s; rt = t; offset = off;
    @(posedge clk); #1;                     // edge N: start sampled
    start = 1'b0;
    rf_we = 1'b0;
    if (junk) begin
      start = 1'b1; op = ~o; rs = 5'd17; rt = 5'd23; offset = 8'h00;
      rf_we = 1'b1; rf_waddr = 5'd23; rf_wdata = 16'h5555;
    end
    chk({tag, " busy@N"}, 16'(busy), 16'd1);
    chk({tag, " done@N"}, 16'(done), 16'd0);
    @(posedge clk); #1;                     // edge N+1
    chk({tag, " busy@N+1"}, 16'(busy), 16'd1);
    chk({tag, " done@N+1"}, 16'(done), 16'd0);
    @(posedge clk); #1;                     // edge N+2: WB, done visible up to edge N+3
    chk({tag, " busy@N+2"}, 16'(busy), 16'd1);
    chk({tag, " done@N+2"}, 16'(done), 16'd1);
    chk({tag, " err"}, 16'(err), 16'(exp_err));
    chk({tag, " mem_out"}, mem_out, exp_mo);
    @(posedge clk); #1;                     // edge N+3: back in IDLE
    start = 1'b0;
    rf_we = 1'b0;
    chk({tag, " busy@N+3"}, 16'(busy), 16'd0);
    chk({tag, " done@N+3"}, 16'(done), 16'd0);
    chk({tag, " err@N+3"}, 16'(err), 16'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst err", 16'(err), 16'd0);
    chk("rst mem_out", mem_out, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // SW then LW through the same EA
    preload(5'd16, 16'h0033);
    preload(5'd17, 16'hBEEF);
    rd("R16 preload", 5'd16, 16'h0033);
    run_op("sw 0x37", 1'b1, 5'd16, 5'd17, 8'h04, 1'b0, 16'h0000, 1'b0);
    run_op("lw 0x37", 1'b0, 5'd16, 5'd18, 8'h04, 1'b0, 16'hBEEF, 1'b0);
    rd("R18 lw 0x37", 5'd18, 16'hBEEF);

    // Negative offset: 0x33 - 4 = 0x2F
    preload(5'd19, 16'h1234);
    run_op("sw 0x2f", 1'b1, 5'd16, 5'd19, 8'hFC, 1'b0, 16'hBEEF, 1'b0);
    run_op("lw 0x2f", 1'b0, 5'd16, 5'd18, 8'hFC, 1'b0, 16'h1234, 1'b0);
    rd("R18 lw 0x2f", 5'd18, 16'h1234);

    // Out of range: EA = 0x100
    preload(5'd20, 16'h0100);
    run_op("lw oor", 1'b0, 5'd20, 5'd18, 8'h00, 1'b1, 16'h1234, 1'b0);
    rd("R18 after oor", 5'd18, 16'h1234);

    // Last valid word: EA = 0xF0 + 0x0F = 0xFF
    preload(5'd20, 16'h00F0);
    run_op("sw 0xff", 1'b1, 5'd20, 5'd17, 8'h0F, 1'b0, 16'h1234, 1'b0);
    run_op("lw 0xff", 1'b0, 5'd20, 5'd21, 8'h0F, 1'b0, 16'hBEEF, 1'b0);
    rd("R21 lw 0xff", 5'd21, 16'hBEEF);

    // Wrapping EA: 0xFFFF + 2 = 0x0001
    preload(5'd20, 16'hFFFF);
    run_op("sw wrap", 1'b1, 5'd20, 5'd19, 8'h02, 1'b0, 16'hBEEF, 1'b0);
    run_op("lw wrap", 1'b0, 5'd20, 5'd21, 8'h02, 1'b0, 16'h1234, 1'b0);
    rd("R21 lw wrap", 5'd21, 16'h1234);

    // start and rf_we held high while busy are ignored
    run_op("lw junk", 1'b0, 5'd16, 5'd22, 8'h04, 1'b0, 16'hBEEF, 1'b1);
    rd("R22 lw junk", 5'd22, 16'hBEEF);
    rd("R23 untouched", 5'd23, 16'h0000);
    @(posedge clk); #1;
    chk("no queued start", 16'(busy), 16'd0);

    // Writes to R0 are discarded
    run_op("lw r0", 1'b0, 5'd16, 5'd0, 8'h04, 1'b0, 16'hBEEF, 1'b0);
    rd("R0 after lw", 5'd0, 16'h0000);
    preload(5'd0, 16'hAAAA);
    rd("R0 after preload", 5'd0, 16'h0000);

    // Preload together with start: ADDR sees the new base 0x30 + 7 = 0x37
    rf_we = 1'b1; rf_waddr = 5'd24; rf_wdata = 16'h0030;
    run_op("lw pre+start", 1'b0, 5'd24, 5'd25, 8'h07, 1'b0, 16'hBEEF, 1'b0);
    rd("R25 pre+start", 5'd25, 16'hBEEF);

    // Reset during MEM of an LW
    start = 1'b1; op = 1'b0; rs = 5'd16; rt = 5'd18; offset = 8'h04;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", 16'(busy), 16'd0);
    chk("midrst done", 16'(done), 16'd0);
    chk("midrst mem_out", mem_out, 16'h0000);
    rd("midrst R16", 5'd16, 16'h0000);
    rd("midrst R18", 5'd18, 16'h0000);
    rd("midrst R17", 5'd17, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post-rst no done", 16'(done), 16'd0);
    end

    // Fresh SW/LW pair after reset; memory contents survive reset
    preload(5'd1, 16'h0010);
    preload(5'd2, 16'hCAFE);
    run_op("sw 0x15", 1'b1, 5'd1, 5'd2, 8'h05, 1'b0, 16'h0000, 1'b0);
    run_op("lw 0x15", 1'b0, 5'd1, 5'd3, 8'h05, 1'b0, 16'hCAFE, 1'b0);
    rd("R3 lw 0x15", 5'd3, 16'hCAFE);
    run_op("lw keep 0x37", 1'b0, 5'd1, 5'd4, 8'h27, 1'b0, 16'hBEEF, 1'b0);
    rd("R4 mem kept", 5'd4, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
